io_timer8: RTL

IO_TIMER8 -- requirements
Module: io_timer8

---
 rtl/io_timer8.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/io_timer8.sv
// 8-bit I/O-mapped timer/counter with 10-bit prescaler, compare-match (CTC)
// and overflow flags, and a single registered interrupt request.
module io_timer8 #(
  parameter logic [7:0] ADDR_TCCR  = 8'h33,
  parameter logic [7:0] ADDR_TCNT  = 8'h32,
  parameter logic [7:0] ADDR_OCR   = 8'h3C,
  parameter logic [7:0] ADDR_TIMSK = 8'h39,
  parameter logic [7:0] ADDR_TIFR  = 8'h38
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] io_addr,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       irq,
  input  logic       irq_ack,
  output logic       irq_vec
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 10;
  localparam int unsigned CW = 3;

  // Architectural state
  logic          ctc_q;
  logic [CW-1:0] cs_q;
  logic [DW-1:0] tcnt_q;
  logic [DW-1:0] ocr_q;
  logic          ocie_q;
  logic          toie_q;
  logic          ocf_q;
  logic          tov_q;
  logic [PW-1:0] presc_q;

  // Address decode and write strobes
  logic sel_tccr_c, sel_tcnt_c, sel_ocr_c, sel_timsk_c, sel_tifr_c;
  logic we_tccr_c, we_tcnt_c, we_ocr_c, we_timsk_c, we_tifr_c;

  assign sel_tccr_c  = (io_addr == ADDR_TCCR);
  assign sel_tcnt_c  = (io_addr == ADDR_TCNT);
  assign sel_ocr_c   = (io_addr == ADDR_OCR);
  assign sel_timsk_c = (io_addr == ADDR_TIMSK);
  assign sel_tifr_c  = (io_addr == ADDR_TIFR);

  assign we_tccr_c  = io_we & sel_tccr_c;
  assign we_tcnt_c  = io_we & sel_tcnt_c;
  assign we_ocr_c   = io_we & sel_ocr_c;
  assign we_timsk_c = io_we & sel_timsk_c;
  assign we_tifr_c  = io_we & sel_tifr_c;

  // Clock-select tick: divisor taps on the all-ones pattern of the prescaler
  logic tick_c;

  always_comb begin
    tick_c = 1'b0;
    case (cs_q)
      CW'(1):  tick_c = 1'b1;
      CW'(2):  tick_c = &presc_q[2:0];
      CW'(3):  tick_c = &presc_q[5:0];
      CW'(4):  tick_c = &presc_q[7:0];
      CW'(5):  tick_c = &presc_q[9:0];
      default: tick_c = 1'b0;
    endcase
  end

  logic [PW-1:0] presc_d_c;

  assign presc_d_c = (cs_q == '0) ? '0 : presc_q + PW'(1);

  // Counter advance; a CPU write to TCNT suppresses the tick and its flags
  logic          match_c;
  logic [DW-1:0] tcnt_d_c;
  logic          ocf_set_c;
  logic          tov_set_c;

  assign match_c = (tcnt_q == ocr_q);

  always_comb begin
    tcnt_d_c  = tcnt_q;
    ocf_set_c = 1'b0;
    tov_set_c = 1'b0;
    if (we_tcnt_c) begin
      tcnt_d_c = io_wdata;
    end else if (tick_c) begin
      ocf_set_c = match_c;
      if (ctc_q && match_c) begin
        tcnt_d_c = '0;
      end else begin
        tcnt_d_c  = tcnt_q + DW'(1);
        tov_set_c = ~ctc_q & (&tcnt_q);
      end
    end
  end

  // Flag clears from write-1-to-clear or from acknowledging the pending source
  logic ack_ok_c;
  logic ocf_clr_c;
  logic tov_clr_c;
  logic ocf_d_c;
  logic tov_d_c;

  assign ack_ok_c  = irq_ack & irq;
  assign ocf_clr_c = (we_tifr_c & io_wdata[1]) | (ack_ok_c & irq_vec);
  assign tov_clr_c = (we_tifr_c & io_wdata[0]) | (ack_ok_c & ~irq_vec);

  // A hardware set in the same cycle as a clear keeps the flag
  assign ocf_d_c = ocf_set_c | (ocf_q & ~ocf_clr_c);
  assign tov_d_c = tov_set_c | (tov_q & ~tov_clr_c);

  logic [1:0] pend_c;

  assign pend_c = {ocf_q & ocie_q, tov_q & toie_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctc_q   <= 1'b0;
      cs_q    <= '0;
      tcnt_q  <= '0;
      ocr_q   <= '0;
      ocie_q  <= 1'b0;
      toie_q  <= 1'b0;
      ocf_q   <= 1'b0;
      tov_q   <= 1'b0;
      presc_q <= '0;
      irq     <= 1'b0;
      irq_vec <= 1'b0;
    end else begin
      if (we_tccr_c) begin
        ctc_q <= io_wdata[3];
        cs_q  <= io_wdata[2:0];
      end
      if (we_ocr_c) begin
        ocr_q <= io_wdata;
      end
      if (we_timsk_c) begin
        ocie_q <= io_wdata[1];
        toie_q <= io_wdata[0];
      end
      tcnt_q  <= tcnt_d_c;
      ocf_q   <= ocf_d_c;
      tov_q   <= tov_d_c;
      presc_q <= presc_d_c;
      irq     <= |pend_c;
      irq_vec <= pend_c[1];
    end
  end

  // Combinational read port, zero when idle so it can be OR-merged
  always_comb begin
    io_rdata = '0;
    if (io_re) begin
      if (sel_tccr_c) begin
        io_rdata = {4'b0000, ctc_q, cs_q};
      end else if (sel_tcnt_c) begin
        io_rdata = tcnt_q;
      end else if (sel_ocr_c) begin
        io_rdata = ocr_q;
      end else if (sel_timsk_c) begin
        io_rdata = {6'b000000, ocie_q, toie_q};
      end else if (sel_tifr_c) begin
        io_rdata = {6'b000000, ocf_q, tov_q};
      end
    end
  end

endmodule
